// File: rtl/cpu_trace_buffer_if.sv
// CPU debug-observation bus (pc/ir/rd/aluStatus) plus the 16-bit trace word stream.
// master drives the CPU fields and outReady; slave is the trace buffer.
interface cpu_trace_buffer_if;
  logic [15:0] pc;
  logic [15:0] ir;
  logic [15:0] rd;
  logic [3:0]  aluStatus;
  logic [15:0] outData;
  logic        outValid;
  logic        outLast;
  logic        outReady;

  modport master (
    output pc, ir, rd, aluStatus, outReady,
    input  outData, outValid, outLast
  );

  modport slave (
    input  pc, ir, rd, aluStatus, outReady,
    output outData, outValid, outLast
  );
endinterface

// File: rtl/cpu_trace_buffer.sv
// Captures one {aluStatus, pc, ir, rd} record per new pc into a FIFO and drains it as 4-word records.
// Optional TRACE_TRIGGER_EN adds trigPc/armed: capture is held off until pc first equals trigPc.
module cpu_trace_buffer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  cpu_trace_buffer_if.slave    dbg,
  input  logic                 capEn,
  input  logic                 clr,
  output logic [AW:0]          count,
  output logic                 overflow,
  output logic [CNT_W-1:0]     dropCount
`ifdef TRACE_TRIGGER_EN
  ,
  input  logic [15:0]          trigPc,
  output logic                 armed
`endif
);
  localparam int            REC_W    = 52;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, SEND} state_t;

  logic [REC_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr, w_nxt_rptr;
  logic [AW:0]      r_count, w_cnt_after;
  logic [15:0]      r_lastPc;
  logic             r_haveLast;
  logic             r_ovf;
  logic [CNT_W-1:0] r_drop;
  state_t           r_state, w_nxt_state;
  logic [1:0]       r_idx, w_nxt_idx;
  logic [15:0]      r_data, w_nxt_data;
  logic             r_last, w_nxt_last;
  logic             w_gate, w_cap, w_full, w_push, w_drop, w_pop;
  logic [REC_W-1:0] w_rec, w_rd_rec;

  function automatic logic [15:0] word_sel(input logic [REC_W-1:0] rec, input logic [1:0] idx);
    case (idx)
      2'd0:    return rec[47:32];
      2'd1:    return rec[31:16];
      2'd2:    return rec[15:0];
      default: return {12'h000, rec[51:48]};
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

`ifdef TRACE_TRIGGER_EN
  logic r_armed;
  // The trigger cycle itself passes the gate so the trigger instruction is recorded.
  assign w_gate = r_armed | (dbg.pc == trigPc);
  assign armed  = r_armed;
`else
  assign w_gate = 1'b1;
`endif

  assign w_rec       = {dbg.aluStatus, dbg.pc, dbg.ir, dbg.rd};
  assign w_cap       = capEn & w_gate & (~r_haveLast | (dbg.pc != r_lastPc));
  assign w_full      = (r_count == FULL_CNT);
  assign w_push      = w_cap & ~w_full;
  assign w_drop      = w_cap & w_full;
  assign w_pop       = (r_state == SEND) & dbg.outReady & (r_idx == 2'd3);
  assign w_cnt_after = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
  assign w_nxt_rptr  = w_pop ? r_rptr + 1'b1 : r_rptr;
  // A record pushed into an otherwise-draining FIFO is forwarded so the stream has no bubble.
  assign w_rd_rec    = (w_push && (r_wptr == w_nxt_rptr)) ? w_rec : r_mem[w_nxt_rptr];

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_idx   = r_idx;
    w_nxt_data  = r_data;
    w_nxt_last  = r_last;
    case (r_state)
      IDLE: begin
        if (r_count != '0) begin
          w_nxt_state = SEND;
          w_nxt_idx   = 2'd0;
          w_nxt_data  = word_sel(r_mem[r_rptr], 2'd0);
          w_nxt_last  = 1'b0;
        end
      end
      SEND: begin
        if (dbg.outReady) begin
          if (r_idx == 2'd3) begin
            w_nxt_idx  = 2'd0;
            w_nxt_last = 1'b0;
            if (w_cnt_after != '0) w_nxt_data  = word_sel(w_rd_rec, 2'd0);
            else                   w_nxt_state = IDLE;
          end else begin
            w_nxt_idx  = r_idx + 2'd1;
            w_nxt_data = word_sel(r_mem[r_rptr], r_idx + 2'd1);
            w_nxt_last = (r_idx == 2'd2);
          end
        end
      end
      default: w_nxt_state = IDLE;
    endcase
  end

  // ---- control / output register stage ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_idx      <= 2'd0;
      r_data     <= '0;
      r_last     <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_ovf      <= 1'b0;
      r_drop     <= '0;
      r_haveLast <= 1'b0;
`ifdef TRACE_TRIGGER_EN
      r_armed    <= 1'b0;
`endif
    end else begin
      r_state    <= w_nxt_state;
      r_idx      <= w_nxt_idx;
      r_data     <= w_nxt_data;
      r_last     <= w_nxt_last;
      r_rptr     <= w_nxt_rptr;
      r_count    <= w_cnt_after;
      r_haveLast <= 1'b1;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_drop) begin
        r_ovf  <= 1'b1;
        r_drop <= clr ? CNT_W'(1) : sat_inc(r_drop);
      end else if (clr) begin
        r_ovf  <= 1'b0;
        r_drop <= '0;
      end
`ifdef TRACE_TRIGGER_EN
      if (dbg.pc == trigPc) r_armed <= 1'b1;
`endif
    end
  end

  // ---- data storage stage (no reset) ----
  always_ff @(posedge clk) begin
    r_lastPc <= dbg.pc;
    if (w_push) r_mem[r_wptr] <= w_rec;
  end

  assign dbg.outData  = r_data;
  assign dbg.outValid = (r_state == SEND);
  assign dbg.outLast  = r_last;
  assign count        = r_count;
  assign overflow     = r_ovf;
  assign dropCount    = r_drop;
endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Randomized bench for cpu_trace_buffer checked cycle-by-cycle against a queue-based trace model.
module tb_cpu_trace_buffer;
  localparam int          DEPTH = 16;
  localparam int          AW    = 4;
  localparam int          CNT_W = 8;
  localparam logic [15:0] TRIG  = 16'h0040;

  logic             clk = 1'b0;
  logic             rst, capEn, clr;
  logic [AW:0]      count;
  logic             overflow;
  logic [CNT_W-1:0] dropCount;
`ifdef TRACE_TRIGGER_EN
  logic [15:0]      trigPc;
  logic             armed;
`endif

  always #5 clk = ~clk;

  cpu_trace_buffer_if bus ();

  cpu_trace_buffer #(.DEPTH(DEPTH), .AW(AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .dbg(bus.slave), .capEn(capEn), .clr(clr),
    .count(count), .overflow(overflow), .dropCount(dropCount)
`ifdef TRACE_TRIGGER_EN
    , .trigPc(trigPc), .armed(armed)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: records still owed to the sink, word position within the head record.
  logic [51:0] q[$];
  int          widx;
  bit          mvalid, movf, mhave, marmed;
  int          mdrop;
  logic [15:0] mlast;
  logic [15:0] cur_pc;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] word_of(input logic [51:0] r, input int i);
    case (i)
      0:       return r[47:32];
      1:       return r[31:16];
      2:       return r[15:0];
      default: return {12'h000, r[51:48]};
    endcase
  endfunction

  task automatic cycle(input bit r, input bit ce, input bit cl, input bit rdy, input logic [15:0] p);
    logic [15:0] irv, rdv;
    logic [3:0]  st;
    bit          hs, cap, drop, was_valid;
    int          cnt0;
    irv = 16'($urandom);
    rdv = 16'($urandom);
    st  = 4'($urandom);
    rst = r; capEn = ce; clr = cl;
    bus.outReady = rdy; bus.pc = p; bus.ir = irv; bus.rd = rdv; bus.aluStatus = st;
    if (r) begin
      q.delete(); widx = 0; mvalid = 0; movf = 0; mdrop = 0; mhave = 0; marmed = 0;
    end else begin
      cnt0      = q.size();
      was_valid = mvalid;
      hs        = mvalid && rdy;
      cap       = ce && (!mhave || p != mlast);
`ifdef TRACE_TRIGGER_EN
      cap    = cap && (marmed || p == trigPc);
      marmed = marmed || (p == trigPc);
`endif
      drop = cap && (cnt0 == DEPTH);
      if (hs) begin
        if (widx == 3) begin void'(q.pop_front()); widx = 0; end
        else widx++;
      end
      if (cap && !drop) q.push_back({st, p, irv, rdv});
      mvalid = was_valid ? (q.size() > 0) : (cnt0 > 0);
      if (drop) begin
        movf  = 1;
        mdrop = cl ? 1 : ((mdrop == 255) ? 255 : mdrop + 1);
      end else if (cl) begin
        movf = 0; mdrop = 0;
      end
      mhave = 1;
      mlast = p;
    end
    @(posedge clk);
    #1;
    chk_eq("outValid", bus.outValid, mvalid);
    chk_eq("count", count, q.size());
    chk_eq("overflow", overflow, movf);
    chk_eq("dropCount", dropCount, mdrop);
    if (mvalid) begin
      chk_eq("outData", bus.outData, word_of(q[0], widx));
      chk_eq("outLast", bus.outLast, widx == 3);
    end
    if (r) begin
      chk_eq("rst_outData", bus.outData, 16'h0000);
      chk_eq("rst_outLast", bus.outLast, 1'b0);
    end
`ifdef TRACE_TRIGGER_EN
    chk_eq("armed", armed, marmed);
`endif
  endtask

  task automatic run(input int n, input int p_cap, input int p_rdy, input int p_chg,
                     input int p_clr, input int p_rst);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 99) < p_chg)
        cur_pc = ($urandom_range(0, 9) == 0) ? TRIG : 16'($urandom);
      cycle($urandom_range(0, 99) < p_rst, $urandom_range(0, 99) < p_cap,
            $urandom_range(0, 99) < p_clr, $urandom_range(0, 99) < p_rdy, cur_pc);
    end
  endtask

  initial begin
`ifdef TRACE_TRIGGER_EN
    trigPc = TRIG;
`endif
    cur_pc = 16'h1111;
    cycle(1, 0, 0, 0, cur_pc);
    cycle(1, 0, 0, 0, cur_pc);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, cur_pc);
    // Three instructions held back by a stalled sink.
    cycle(0, 1, 0, 0, 16'h0000);
    cycle(0, 1, 0, 0, 16'h0002);
    cycle(0, 1, 0, 0, 16'h0004);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 16'h0004);
    for (int i = 0; i < 16; i++) cycle(0, 0, 0, 1, 16'h0004);
`ifdef TRACE_TRIGGER_EN
    cycle(1, 0, 0, 0, 16'h0000);
    for (int p = 16'h0038; p <= 16'h0048; p += 2) cycle(0, 1, 0, 1, 16'(p));
    for (int i = 0; i < 24; i++) cycle(0, 0, 0, 1, 16'h0048);
`endif
    cur_pc = 16'h0100;
    run(300, 80, 100, 60, 0, 0);
    run(40, 100, 0, 100, 0, 0);
    run(80, 0, 100, 0, 0, 0);
    run(300, 100, 0, 100, 0, 0);
    run(100, 0, 100, 0, 5, 0);
    run(600, 100, 90, 50, 2, 0);
    run(1500, 70, 70, 50, 3, 1);
    run(100, 0, 100, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
